led_sweeper: RTL



---
 rtl/led_sweep_pkg.sv | 20 ++
 rtl/led_sweeper_strobe_div.sv | 46 ++++
 rtl/led_sweeper.sv | 99 +++++++++
 3 files changed

// File: rtl/led_sweep_pkg.sv
// Shared definitions for the LED sweeper: mode encoding, direction encoding
// and a width helper used by the sweeper and its prescaler.
package led_sweep_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'b00,
    MODE_ROT_L  = 2'b01,
    MODE_ROT_R  = 2'b10,
    MODE_FREEZE = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_sweeper_strobe_div.sv
// Enable-gated prescaler: emits a one-cycle strobe on every CLK_DIV-th
// enabled cycle. With CLK_DIV=1 the strobe is simply i_en.
module strobe_div
  import led_sweep_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_en,
  output logic o_stb
);

  localparam int CW = width_of(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("strobe_div: CLK_DIV must be >= 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_stb = i_en && (cnt_q == LAST);

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (o_stb) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_sweeper.sv
// One-hot LED pattern generator: bounce / rotate-left / rotate-right / freeze
// sweep with a prescaled step rate, position/direction outputs and a wrap pulse.
module led_sweeper
  import led_sweep_pkg::*;
#(
  parameter int NLEDS   = 8,
  parameter int CLK_DIV = 1,
  parameter int PW      = width_of(NLEDS)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  output logic [NLEDS-1:0] o_led,
  output logic [PW-1:0]    o_pos,
  output logic             o_dir,
  output logic             o_wrap
);

  localparam logic [PW-1:0]    LAST = PW'(NLEDS - 1);
  localparam logic [NLEDS-1:0] ONE  = NLEDS'(1);

  if (NLEDS < 2) begin : g_bad_nleds
    $error("led_sweeper: NLEDS must be >= 2");
  end

  logic             stb;
  logic [PW-1:0]    pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [NLEDS-1:0] led_q, led_d;
  logic             wrap_q, wrap_d;
  logic             eff_dir;

  strobe_div #(
    .CLK_DIV(CLK_DIV)
  ) u_strobe_div (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_en     (i_en),
    .o_stb    (stb)
  );

  always_comb begin
    pos_d   = pos_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    eff_dir = dir_q;
    if (stb) begin
      case (mode_e'(i_mode))
        MODE_BOUNCE: begin
          // Ends force the direction, so entering bounce at an end turns
          // around on the very first step.
          if (pos_q == '0) begin
            eff_dir = DIR_UP;
          end else if (pos_q == LAST) begin
            eff_dir = DIR_DOWN;
          end
          pos_d  = (eff_dir == DIR_DOWN) ? pos_q - PW'(1) : pos_q + PW'(1);
          dir_d  = eff_dir;
          wrap_d = (eff_dir == DIR_DOWN) && (pos_q == PW'(1));
        end
        MODE_ROT_L: begin
          pos_d  = (pos_q == LAST) ? '0 : pos_q + PW'(1);
          dir_d  = DIR_UP;
          wrap_d = (pos_q == LAST);
        end
        MODE_ROT_R: begin
          pos_d  = (pos_q == '0) ? LAST : pos_q - PW'(1);
          dir_d  = DIR_DOWN;
          wrap_d = (pos_q == '0);
        end
        default: begin
          // Freeze: the tick is consumed with no movement.
        end
      endcase
    end
    led_d = ONE << pos_d;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pos_q  <= '0;
      dir_q  <= DIR_UP;
      led_q  <= ONE;
      wrap_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
      wrap_q <= wrap_d;
    end
  end

  assign o_led  = led_q;
  assign o_pos  = pos_q;
  assign o_dir  = dir_q;
  assign o_wrap = wrap_q;

endmodule
